// File: rtl/sd_spi_responder.sv
// rtl/sd_spi_responder.sv - SD card SPI-mode responder: init handshake, CMD8/CMD58 trailers, single-block read
module sd_spi_responder #(
    parameter int INIT_POLLS = 2,
    parameter int NCR_BYTES  = 1
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        sd_clock,
    input  logic        sd_dat3,
    input  logic        sd_cmd,
    output logic        sd_dat,
    output logic [17:0] mem_addr,
    input  logic [7:0]  mem_rdata,
    output logic        cmd_strobe,
    output logic [5:0]  cmd_index,
    output logic        card_ready
);
    typedef enum logic [2:0] {RX_CMD, NCR, R1, TRAIL, RD_GAP, TOKEN, DATA, CRC} state_t;

    localparam logic [2:0] NCR_LAST   = 3'(NCR_BYTES - 1);
    localparam logic [7:0] POLLS_INIT = 8'(INIT_POLLS);

    state_t      state, state_next;
    logic        sclk_m, sclk_s, sclk_d, cs_m, cs_s, cs_d, mosi_m, mosi_s;
    logic [2:0]  bit_cnt, byte_cnt, cnt;
    logic [8:0]  data_cnt, block, arg;
    logic [6:0]  rx_sh;
    logic [7:0]  tx_sh, r1, polls, rx_byte, tx_byte, dec_r1;
    logic [31:0] trail, dec_trail;
    logic [5:0]  idx_pend;
    logic        idle, app, has_trail, has_data, dec_trail_en, dec_data_en;
    logic        rise, fall, cs_rise, cs_fall, byte_done;

    // SCLK edges are ignored while the card is deselected (host init clocks)
    assign rise      = sclk_s & ~sclk_d & ~cs_s;
    assign fall      = ~sclk_s & sclk_d & ~cs_s;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign rx_byte   = {rx_sh, mosi_s};
    assign byte_done = rise && (bit_cnt == 3'd7);
    assign sd_dat    = sd_dat3 | cs_s | tx_sh[7];

    always_comb begin
        dec_r1       = idle ? 8'h05 : 8'h04;
        dec_trail_en = 1'b0;
        dec_data_en  = 1'b0;
        dec_trail    = 32'hC0FF_8000;
        case (idx_pend)
            6'd0:  dec_r1 = 8'h01;
            6'd8: begin
                dec_r1       = {7'd0, idle};
                dec_trail_en = 1'b1;
                dec_trail    = {16'h0000, 8'h01, arg[7:0]};
            end
            6'd58: begin
                dec_r1       = {7'd0, idle};
                dec_trail_en = 1'b1;
            end
            6'd55: dec_r1 = {7'd0, idle};
            6'd41: if (app) dec_r1 = (polls != 8'd0) ? 8'h01 : 8'h00;
            6'd17: begin
                if (!idle) begin
                    dec_r1      = 8'h00;
                    dec_data_en = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // state names the byte currently on the wire; tx_byte is what it loads
    always_comb begin
        state_next = state;
        tx_byte    = 8'hFF;
        case (state)
            RX_CMD: if (byte_done && byte_cnt == 3'd5) state_next = NCR;
            NCR:    if (byte_done && cnt == NCR_LAST) state_next = R1;
            R1: begin
                tx_byte = r1;
                if (byte_done) state_next = has_trail ? TRAIL : (has_data ? RD_GAP : RX_CMD);
            end
            TRAIL: begin
                tx_byte = trail[31:24];
                if (byte_done && cnt == 3'd3) state_next = RX_CMD;
            end
            RD_GAP: if (byte_done) state_next = TOKEN;
            TOKEN: begin
                tx_byte = 8'hFE;
                if (byte_done) state_next = DATA;
            end
            DATA: begin
                tx_byte = mem_rdata;
                if (byte_done && data_cnt == 9'd511) state_next = CRC;
            end
            CRC:     if (byte_done && cnt == 3'd1) state_next = RX_CMD;
            default: state_next = RX_CMD;
        endcase
        if (cs_rise) state_next = RX_CMD;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) state <= RX_CMD;
        else                state <= state_next;
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            {sclk_m, sclk_s, sclk_d} <= 3'b000;
            {cs_m, cs_s, cs_d}       <= 3'b111;
            {mosi_m, mosi_s}         <= 2'b11;
            bit_cnt    <= 3'd0;
            byte_cnt   <= 3'd0;
            cnt        <= 3'd0;
            data_cnt   <= 9'd0;
            block      <= 9'd0;
            arg        <= 9'd0;
            rx_sh      <= 7'd0;
            tx_sh      <= 8'hFF;
            r1         <= 8'hFF;
            trail      <= 32'd0;
            idx_pend   <= 6'd0;
            has_trail  <= 1'b0;
            has_data   <= 1'b0;
            mem_addr   <= 18'd0;
            cmd_strobe <= 1'b0;
            cmd_index  <= 6'd0;
            card_ready <= 1'b0;
            idle       <= 1'b1;
            app        <= 1'b0;
            polls      <= POLLS_INIT;
        end else begin
            {sclk_m, sclk_s, sclk_d} <= {sd_clock, sclk_m, sclk_s};
            {cs_m, cs_s, cs_d}       <= {sd_dat3, cs_m, cs_s};
            {mosi_m, mosi_s}         <= {sd_cmd, mosi_m};
            cmd_strobe <= 1'b0;

            if (state_next != state) cnt <= 3'd0;
            else if (byte_done)      cnt <= cnt + 3'd1;

            if (state != DATA)                          data_cnt <= 9'd0;
            else if (byte_done && data_cnt != 9'd511)   data_cnt <= data_cnt + 9'd1;

            if (cs_rise) begin
                bit_cnt  <= 3'd0;
                byte_cnt <= 3'd0;
                tx_sh    <= 8'hFF;
            end else begin
                if (rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    rx_sh   <= rx_byte[6:0];
                end
                if (fall)         tx_sh <= (bit_cnt == 3'd0) ? tx_byte : {tx_sh[6:0], 1'b1};
                else if (cs_fall) tx_sh <= tx_byte;

                // prefetch one byte ahead so mem_rdata settles long before its load
                if (rise && bit_cnt == 3'd0) begin
                    if (state == TOKEN)     mem_addr <= {block, 9'd0};
                    else if (state == DATA) mem_addr <= {block, data_cnt + 9'd1};
                end

                if (byte_done && state == TRAIL) trail <= {trail[23:0], 8'h00};

                if (byte_done && state == RX_CMD) begin
                    if (byte_cnt == 3'd0) begin
                        if (rx_byte[7:6] == 2'b01) begin
                            idx_pend <= rx_byte[5:0];
                            byte_cnt <= 3'd1;
                        end
                    end else if (byte_cnt != 3'd5) begin
                        arg      <= {arg[0], rx_byte};
                        byte_cnt <= byte_cnt + 3'd1;
                    end else begin
                        byte_cnt   <= 3'd0;
                        cmd_strobe <= 1'b1;
                        cmd_index  <= idx_pend;
                        r1         <= dec_r1;
                        trail      <= dec_trail;
                        has_trail  <= dec_trail_en;
                        has_data   <= dec_data_en;
                        block      <= arg;
                        app        <= (idx_pend == 6'd55);
                        if (idx_pend == 6'd0) begin
                            idle       <= 1'b1;
                            card_ready <= 1'b0;
                            polls      <= POLLS_INIT;
                        end else if (idx_pend == 6'd41 && app) begin
                            if (polls != 8'd0) begin
                                polls <= polls - 8'd1;
                            end else begin
                                idle       <= 1'b0;
                                card_ready <= 1'b1;
                            end
                        end
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_sd_spi_responder.sv
// tb/tb_sd_spi_responder.sv - directed plus randomized bench for sd_spi_responder against a command-level card model
module tb_sd_spi_responder;
    localparam int INIT_POLLS = 2;
    localparam int NCR_BYTES  = 1;
    localparam int HALF       = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        sclk = 1'b0;
    logic        cs = 1'b1;
    logic        mosi = 1'b1;
    logic        miso;
    logic [17:0] mem_addr;
    logic [7:0]  mem_rdata = 8'h00;
    logic        cmd_strobe;
    logic [5:0]  cmd_index;
    logic        card_ready;

    int vectors = 0;
    int fails = 0;
    int strobes = 0;
    int exp_strobes = 0;

    bit m_idle = 1'b1;
    bit m_app = 1'b0;
    bit m_ready = 1'b0;
    int m_polls = INIT_POLLS;
    logic [7:0] exp_q[$];

    sd_spi_responder #(.INIT_POLLS(INIT_POLLS), .NCR_BYTES(NCR_BYTES)) dut (
        .clk_clk(clk),
        .reset_reset_n(resetn),
        .sd_clock(sclk),
        .sd_dat3(cs),
        .sd_cmd(mosi),
        .sd_dat(miso),
        .mem_addr(mem_addr),
        .mem_rdata(mem_rdata),
        .cmd_strobe(cmd_strobe),
        .cmd_index(cmd_index),
        .card_ready(card_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mem_fn(input logic [17:0] a);
        return a[7:0];
    endfunction

    always @(posedge clk) mem_rdata <= mem_fn(mem_addr);
    always @(posedge clk) if (resetn && cmd_strobe) strobes <= strobes + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [7:0] tx, output logic [7:0] rx);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            mosi = tx[i];
            repeat (HALF - 1) @(negedge clk);
            rx[i] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    // Card behaviour expressed as the byte stream a host should read back
    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg);
        logic [7:0] r1;
        int kind;
        exp_q.delete();
        for (int k = 0; k < NCR_BYTES; k++) exp_q.push_back(8'hFF);
        r1 = m_idle ? 8'h05 : 8'h04;
        kind = 0;
        case (idx)
            6'd0: begin
                r1 = 8'h01; m_idle = 1'b1; m_ready = 1'b0; m_polls = INIT_POLLS;
            end
            6'd8:  begin r1 = m_idle ? 8'h01 : 8'h00; kind = 1; end
            6'd58: begin r1 = m_idle ? 8'h01 : 8'h00; kind = 2; end
            6'd55: r1 = m_idle ? 8'h01 : 8'h00;
            6'd41: begin
                if (m_app) begin
                    if (m_polls > 0) begin
                        r1 = 8'h01; m_polls--;
                    end else begin
                        r1 = 8'h00; m_idle = 1'b0; m_ready = 1'b1;
                    end
                end
            end
            6'd17: if (!m_idle) begin r1 = 8'h00; kind = 3; end
            default: ;
        endcase
        m_app = (idx == 6'd55);
        exp_strobes++;
        exp_q.push_back(r1);
        if (kind == 1) begin
            exp_q.push_back(8'h00); exp_q.push_back(8'h00);
            exp_q.push_back(8'h01); exp_q.push_back(arg[7:0]);
        end else if (kind == 2) begin
            exp_q.push_back(8'hC0); exp_q.push_back(8'hFF);
            exp_q.push_back(8'h80); exp_q.push_back(8'h00);
        end else if (kind == 3) begin
            exp_q.push_back(8'hFF); exp_q.push_back(8'hFE);
            for (int n = 0; n < 512; n++) exp_q.push_back(mem_fn({arg[8:0], 9'(n)}));
            exp_q.push_back(8'hFF); exp_q.push_back(8'hFF);
        end
    endtask

    task automatic do_cmd(input logic [5:0] idx, input logic [31:0] arg, input int limit, input string tag);
        logic [7:0] rx;
        int n;
        model_cmd(idx, arg);
        xfer({2'b01, idx}, rx);
        for (int k = 3; k >= 0; k--) xfer(arg[8*k +: 8], rx);
        xfer(8'h95, rx);
        n = (limit > 0 && limit < exp_q.size()) ? limit : exp_q.size();
        for (int k = 0; k < n; k++) begin
            xfer(8'($urandom), rx);
            check($sformatf("%s resp[%0d]", tag, k), 32'(rx), 32'(exp_q[k]));
            if (exp_q.size() > 100 && k == 20)
                check($sformatf("%s mem_addr block", tag), 32'(mem_addr[17:9]), 32'(arg[8:0]));
        end
        if (n == exp_q.size()) begin
            xfer(8'hFF, rx);
            check($sformatf("%s idle fill", tag), 32'(rx), 32'hFF);
            check($sformatf("%s strobe count", tag), 32'(strobes), 32'(exp_strobes));
            check($sformatf("%s cmd_index", tag), 32'(cmd_index), 32'(idx));
            check($sformatf("%s card_ready", tag), 32'(card_ready), 32'(m_ready));
        end
    endtask

    initial begin
        logic [7:0] rx;
        logic [5:0] u;
        logic [8:0] blk;
        int pick;

        resetn = 1'b0;
        repeat (5) @(negedge clk);
        check("reset sd_dat", 32'(miso), 32'd1);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset cmd_strobe", 32'(cmd_strobe), 32'd0);
        check("reset cmd_index", 32'(cmd_index), 32'd0);
        check("reset card_ready", 32'(card_ready), 32'd0);
        resetn = 1'b1;

        xfer(8'h40, rx);
        check("cs high miso 0", 32'(rx), 32'hFF);
        xfer(8'h00, rx);
        check("cs high miso 1", 32'(rx), 32'hFF);
        check("cs high no strobe", 32'(strobes), 32'd0);

        @(negedge clk) cs = 1'b0;
        repeat (4) @(negedge clk);

        do_cmd(6'd0, 32'h0, 0, "cmd0");
        do_cmd(6'd8, 32'h1AA, 0, "cmd8");
        do_cmd(6'd8, 32'($urandom), 0, "cmd8 rand");
        do_cmd(6'd17, 32'h3, 0, "cmd17 idle");
        for (int k = 0; k < 4; k++) begin
            xfer(8'hFF, rx);
            check($sformatf("no token %0d", k), 32'(rx), 32'hFF);
        end
        do_cmd(6'd63, 32'h0, 0, "cmd63");
        do_cmd(6'd41, 32'h0, 0, "cmd41 no app");
        for (int k = 0; k < 3; k++) begin
            do_cmd(6'd55, 32'h0, 0, $sformatf("cmd55 #%0d", k));
            do_cmd(6'd41, 32'h4000_0000, 0, $sformatf("acmd41 #%0d", k));
        end

        do_cmd(6'd17, 32'h3, 0, "cmd17 blk3");

        blk = 9'($urandom_range(0, 511));
        do_cmd(6'd17, 32'(blk), NCR_BYTES + 103, "cmd17 abort");
        @(negedge clk) cs = 1'b1;
        repeat (4) @(negedge clk);
        check("cs high sd_dat", 32'(miso), 32'd1);
        xfer(8'h40, rx);
        check("cs high after abort", 32'(rx), 32'hFF);
        @(negedge clk) cs = 1'b0;
        repeat (4) @(negedge clk);
        do_cmd(6'd58, 32'h0, 0, "cmd58 after abort");

        for (int it = 0; it < 8; it++) begin
            pick = $urandom_range(0, 5);
            case (pick)
                0: do_cmd(6'd8, 32'($urandom), 0, $sformatf("rand%0d cmd8", it));
                1: do_cmd(6'd58, 32'($urandom), 0, $sformatf("rand%0d cmd58", it));
                2: do_cmd(6'd55, 32'($urandom), 0, $sformatf("rand%0d cmd55", it));
                3: do_cmd(6'd41, 32'($urandom), 0, $sformatf("rand%0d cmd41", it));
                4: do_cmd(6'd0, 32'($urandom), 0, $sformatf("rand%0d cmd0", it));
                default: begin
                    u = 6'($urandom_range(0, 63));
                    if (u == 6'd0 || u == 6'd8 || u == 6'd17 || u == 6'd41 || u == 6'd55 || u == 6'd58)
                        u = 6'd63;
                    do_cmd(u, 32'($urandom), 0, $sformatf("rand%0d cmd%0d", it, u));
                end
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule

// File: doc/sd_spi_responder.md
SD_SPI_RESPONDER -- requirements
Module: sd_spi_responder

Interface
REQ-001 Parameter INIT_POLLS, default 2: number of ACMD41 commands answered "busy" (0x01) before the card reports ready.
REQ-002 Parameter NCR_BYTES, default 1: number of 0xFF filler bytes between the last command byte and the R1 byte (range 1..8).
REQ-003 Port clk_clk, input, 1: system clock; the only clock.
REQ-004 Port reset_reset_n, input, 1: reset, synchronous to clk_clk, active-low.
REQ-005 Port sd_clock, input, 1: SPI SCLK from the host.
REQ-006 Port sd_dat3, input, 1: SPI chip select, active-low.
REQ-007 Port sd_cmd, input, 1: SPI MOSI.
REQ-008 Port sd_dat, output, 1: SPI MISO.
REQ-009 Port mem_addr, output, 18: backing-store byte address, {block[8:0], offset[8:0]}.
REQ-010 Port mem_rdata, input, 8: backing-store byte, valid one clk_clk cycle after mem_addr changes.
REQ-011 Port cmd_strobe, output, 1: one-cycle pulse when a complete 6-byte command is decoded.
REQ-012 Port cmd_index, output, 6: index of the last decoded command, held until the next command.
REQ-013 Port card_ready, output, 1: high once ACMD41 has returned 0x00.

Function
REQ-014 sd_clock, sd_dat3 and sd_cmd shall each pass through a 2-FF synchronizer; SCLK edges are detected on the synchronized signal; clk_clk shall be at least 8x sd_clock (precondition, not checked).
REQ-015 SPI mode 0, MSB first: MOSI sampled on each SCLK rising edge; MISO updated on each SCLK falling edge; the MSB of each TX byte is presented on sd_dat from the falling edge that ends the previous byte, or from the cycle sd_dat3 falls.
REQ-016 sd_dat shall be 1 whenever sd_dat3 is high or no response byte is queued (idle fill 0xFF).
REQ-017 Bit counter (3 bits) wraps 7->0 on each eighth rising edge; a received byte is complete on that edge.
REQ-018 FSM states: RX_CMD, NCR, R1, TRAIL, RD_GAP, TOKEN, DATA, CRC.
REQ-019 RX_CMD: a received byte with bits[7:6]=01 starts a command; the next 5 bytes are captured (32-bit argument, CRC byte ignored); after byte 6: cmd_strobe pulses, cmd_index updates, go to NCR.
REQ-020 NCR: transmit NCR_BYTES bytes of 0xFF, then R1.
REQ-021 R1 value: bit0 = idle (1 until ACMD41 success); bit2 = illegal command; all other bits 0.
REQ-022 CMD0: R1=0x01; resets idle=1, card_ready=0, poll counter=INIT_POLLS, app flag=0.
REQ-023 CMD8: R1 then TRAIL of 4 bytes 0x00, 0x00, 0x01, arg[7:0].
REQ-024 CMD58: R1 then TRAIL of 4 bytes 0xC0, 0xFF, 0x80, 0x00.
REQ-025 CMD55: normal R1; sets app flag. Any other command clears app flag after its decode.
REQ-026 CMD41 with app flag set: if poll counter > 0, R1=0x01 and decrement; else R1=0x00, idle=0, card_ready=1; a further ACMD41 once ready returns 0x00.
REQ-027 CMD41 without app flag, or any unsupported index: R1 = 0x04 | idle.
REQ-028 CMD17 while idle=1: R1=0x05, no data phase. CMD17 while ready: R1=0x00, RD_GAP (one 0xFF byte), TOKEN (0xFE), DATA (512 bytes), CRC (0xFF, 0xFF), then RX_CMD.
REQ-029 DATA: block = arg[8:0]; byte n is mem_rdata at mem_addr={block, n}; mem_addr is set no later than the first rising edge of the preceding byte, so mem_rdata is stable before its MSB is shifted out.
REQ-030 MOSI bytes received in any state other than RX_CMD are discarded.
REQ-031 A rising edge on synchronized sd_dat3 in any state aborts to RX_CMD and clears the bit and byte counters; init state (idle, poll counter, app flag) is kept.
REQ-032 The 9-bit DATA counter runs 0..511; after 511 the FSM moves to CRC with no wrap.

Reset
REQ-033 With reset_reset_n low at a clk_clk edge: state RX_CMD, counters 0, sd_dat=1, mem_addr=0, cmd_strobe=0, cmd_index=0, card_ready=0, idle=1, app flag=0, poll counter=INIT_POLLS. A reset mid-transfer truncates the transfer immediately.

Verification
REQ-034 CS low, send 40 00 00 00 00 95 -> cmd_strobe pulse, cmd_index=0; host reads FF then 01.
REQ-035 Send 48 00 00 01 AA 87 -> reads FF, 01, 00, 00, 01, AA.
REQ-036 With INIT_POLLS=2, send (CMD55, ACMD41) three times -> ACMD41 R1 = 01, 01, 00; card_ready rises after the third.
REQ-037 When ready, send CMD17 with arg=0x00000003, mem model byte = addr[7:0] -> FF, 00, FF, FE, 00..FF twice (512 bytes), FF, FF; mem_addr upper bits = 3.
REQ-038 CMD17 before init -> R1=05, no FE token ever appears; unknown CMD63 -> R1=05.
REQ-039 Raise sd_dat3 after 100 data bytes, lower it, send CMD58 -> clean R1=00 followed by C0 FF 80 00; sd_dat=1 while sd_dat3 high.
